// File: rtl/pid_pwm_pkg.sv
// Shared definitions for the PID PWM output stage: channel FSM encodings and
// the saturating absolute value used to turn a signed command into a duty.
package pid_pwm_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DEAD  = 2'd1,
        ST_ALIGN = 2'd2
    } chan_state_e;

    // v is a w-bit signed value sign-extended to 32 bits; the most negative
    // w-bit value saturates to 2^(w-1)-1 so the magnitude always fits w-1 bits.
    function automatic logic [31:0] sat_abs(input logic signed [31:0] v, input int w);
        logic signed [31:0] most_neg;
        most_neg = -(32'sd1 <<< (w - 1));
        if (v == most_neg)
            sat_abs = (32'd1 << (w - 1)) - 32'd1;
        else if (v < 0)
            sat_abs = 32'(-v);
        else
            sat_abs = 32'(v);
    endfunction

endpackage

// File: rtl/pid_pwm_chan.sv
// One sign/magnitude PWM channel: period-aligned shadow duty, dead-time FSM on
// direction reversal, and registered pwm/dir outputs.
module pid_pwm_chan
    import pid_pwm_pkg::*;
#(
    parameter int OW       = 12,
    parameter int DEADTIME = 16
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 ld_i,
    input  logic [OW-2:0]        cnt_i,
    input  logic signed [OW-1:0] cmd_i,
    input  logic                 en_i,
    output logic                 pwm_o,
    output logic                 dir_o,
    output chan_state_e          state_o
);

    localparam int MW = OW - 1;
    localparam logic [MW-1:0] DT_LAST = MW'(DEADTIME - 1);

    chan_state_e   state_q, state_d;
    logic [MW-1:0] duty_q, duty_d;
    logic          tneg_q, tneg_d;
    logic [MW-1:0] dtcnt_q, dtcnt_d;
    logic          dir_q, dir_d;
    logic          pwm_q, pwm_d;

    logic [MW-1:0] ld_mag;
    logic          ld_neg;
    logic [MW-1:0] duty_eff;
    logic          reversal;

    // On a load cycle the compare already uses the incoming duty, so each
    // period starts cleanly with its own value.
    assign ld_mag   = MW'(sat_abs(32'(cmd_i), OW));
    assign ld_neg   = cmd_i[OW-1];
    assign duty_eff = ld_i ? ld_mag : duty_q;
    assign reversal = ld_i && (ld_mag != '0) && (ld_neg != dir_q);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_RUN;
            duty_q  <= '0;
            tneg_q  <= 1'b0;
            dtcnt_q <= '0;
            dir_q   <= 1'b0;
            pwm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            tneg_q  <= tneg_d;
            dtcnt_q <= dtcnt_d;
            dir_q   <= dir_d;
            pwm_q   <= pwm_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dtcnt_d = dtcnt_q;
        dir_d   = dir_q;
        duty_d  = duty_eff;
        tneg_d  = ld_i ? ld_neg : tneg_q;
        case (state_q)
            ST_RUN: begin
                if (reversal) begin
                    state_d = ST_DEAD;
                    dtcnt_d = '0;
                end
            end
            ST_DEAD: begin
                dtcnt_d = dtcnt_q + MW'(1);
                if (dtcnt_q == DT_LAST) begin
                    dir_d   = tneg_q;
                    state_d = ST_ALIGN;
                end
            end
            ST_ALIGN: begin
                if (ld_i) begin
                    if (reversal) begin
                        state_d = ST_DEAD;
                        dtcnt_d = '0;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        pwm_d = 1'b0;
        case (state_q)
            ST_RUN:   pwm_d = !reversal && (cnt_i < duty_eff) && en_i;
            ST_ALIGN: pwm_d = ld_i && !reversal && (cnt_i < duty_eff) && en_i;
            default:  pwm_d = 1'b0;
        endcase
    end

    assign pwm_o   = pwm_q;
    assign dir_o   = dir_q;
    assign state_o = state_q;

endmodule

// File: rtl/pid_pwm_out.sv
// PID output stage: per-address command capture, shared PWM period counter and
// one sign/magnitude PWM channel per PID address.
module pid_pwm_out
    import pid_pwm_pkg::*;
#(
    parameter int aw       = 1,
    parameter int ow       = 12,
    parameter int deadtime = 16
) (
    input  logic                    clk_pid,
    input  logic                    reset,
    input  logic                    ce,
    input  logic [aw-1:0]           a,
    input  logic [ow-1:0]           m_k,
    input  logic                    pwm_en,
    output logic [(1<<aw)-1:0]      pwm,
    output logic [(1<<aw)-1:0]      dir,
    output logic [2*(1<<aw)-1:0]    dbg_state_o,
    output logic [ow-2:0]           dbg_cnt_o
);

    localparam int AN = 1 << aw;
    localparam int MW = ow - 1;
    localparam logic [MW-1:0] CNT_LAST = MW'((1 << MW) - 2);

    logic signed [ow-1:0] cmd_q [AN];
    logic [MW-1:0]        cnt_q, cnt_d;
    logic                 ld;
    chan_state_e          st [AN];

    // ce is a valid-only strobe with no back-pressure: every ce is accepted.
    always_ff @(posedge clk_pid) begin
        if (reset) begin
            for (int i = 0; i < AN; i++) cmd_q[i] <= '0;
            cnt_q <= '0;
        end else begin
            if (ce) cmd_q[a] <= m_k;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + MW'(1);
    end

    assign ld        = (cnt_q == '0);
    assign dbg_cnt_o = cnt_q;

    for (genvar i = 0; i < AN; i++) begin : g_chan
        pid_pwm_chan #(
            .OW       (ow),
            .DEADTIME (deadtime)
        ) u_chan (
            .clk_i   (clk_pid),
            .reset_i (reset),
            .ld_i    (ld),
            .cnt_i   (cnt_q),
            .cmd_i   (cmd_q[i]),
            .en_i    (pwm_en),
            .pwm_o   (pwm[i]),
            .dir_o   (dir[i]),
            .state_o (st[i])
        );
        assign dbg_state_o[2*i +: 2] = st[i];
    end

endmodule
